// File: rtl/log2_pkg.sv
// Shared constants and the per-stage record for the log2/ln pipeline.
package log2_pkg;

  localparam int LN2_Q16   = 45426;   // ln(2) in Q0.16
  localparam int LN2_SHIFT = 16;

  localparam int DEF_IN_WIDTH  = 32;
  localparam int DEF_OUT_WIDTH = 16;
  localparam int DEF_FRAC_BITS = 10;
  localparam int DEF_LUT_BITS  = 6;
  localparam int DEF_CHANNELS  = 4;

  // Record widths cover the largest supported parameter set.
  localparam int STAGE_DATA_W = 32;
  localparam int STAGE_CHAN_W = 5;

  typedef struct packed {
    logic                    valid;
    logic [STAGE_CHAN_W-1:0] chan;
    logic                    mode;
    logic                    zero;
    logic [STAGE_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/log2_lut.sv
// Fraction table: round(log2(1 + i/2^LUT_BITS) * 2^FRAC_BITS), built at elaboration.
module log2_lut #(
  parameter int LUT_BITS  = 6,
  parameter int FRAC_BITS = 10
) (
  input  logic [LUT_BITS-1:0] idx,
  output logic [FRAC_BITS:0]  frac
);

  localparam int SIZE = 2 ** LUT_BITS;
  localparam int PREC = 60;

  // Bit-serial log2 by repeated squaring on a 60-bit fixed-point mantissa;
  // one extra result bit is produced so the final step can round to nearest.
  function automatic logic [FRAC_BITS:0] entry(input int i);
    logic [127:0]         x;
    logic [FRAC_BITS+1:0] r;
    logic [FRAC_BITS+1:0] r_rnd;
    x = 128'(SIZE + i) << (PREC - LUT_BITS);
    r = '0;
    for (int b = 0; b <= FRAC_BITS; b++) begin
      x = (x * x) >> PREC;
      r = {r[FRAC_BITS:0], x[PREC+1]};
      if (x[PREC+1]) x = x >> 1;
    end
    r_rnd = r + 1'b1;
    entry = r_rnd[FRAC_BITS+1:1];
  endfunction

  logic [FRAC_BITS:0] lut_rom [SIZE];

  for (genvar g = 0; g < SIZE; g++) begin : g_entry
    localparam logic [FRAC_BITS:0] VAL = entry(g);
    assign lut_rom[g] = VAL;
  end

  assign frac = lut_rom[idx];

endmodule

// File: rtl/log2_pipe.sv
// Four-stage log2 / natural-log pipeline with channel tags and a zero-input flag.
module log2_pipe
  import log2_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int LUT_BITS  = DEF_LUT_BITS,
  parameter int CHANNELS  = DEF_CHANNELS
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [IN_WIDTH-1:0]         filtered_data_in,
  input  logic [$clog2(CHANNELS)-1:0] filtered_chan_in,
  input  logic                        filtered_mode_in,
  input  logic                        filtered_valid_in,
  output logic                        filtered_ready_out,
  output logic [OUT_WIDTH-1:0]        log_data_out,
  output logic [$clog2(CHANNELS)-1:0] log_chan_out,
  output logic                        log_zero_out,
  output logic                        log_valid_out,
  input  logic                        log_ready_in
);

  localparam int CW = $clog2(CHANNELS);
  localparam int KW = $clog2(IN_WIDTH);
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  stage_t                  s1, s2, s3, s4;
  logic [KW-1:0]           s1_k, s2_k;
  logic                    advance;
  logic [KW-1:0]           lod_k;
  logic [IN_WIDTH-1:0]     mant;
  logic [LUT_BITS-1:0]     lut_idx;
  logic [FRAC_BITS:0]      lut_frac;
  logic [STAGE_DATA_W-1:0] log2_val;
  logic [63:0]             prod;
  logic [STAGE_DATA_W-1:0] s4_data;
  logic                    unused_bits;

  // Handshake: a word moves on a side only in a cycle where its valid and
  // ready are both high. The whole pipe advances as one whenever the output
  // register is empty or being taken, so a stall freezes every stage.
  assign advance            = !s4.valid || log_ready_in;
  assign filtered_ready_out = rst_n_in && advance;

  // S1: leading-one detect; lowest-to-highest scan leaves the top set bit.
  always_comb begin
    lod_k = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (filtered_data_in[i]) lod_k = KW'(i);
    end
  end

  // S2: put the leading one at the MSB; the bits just below it index the LUT.
  assign mant    = s1.data[IN_WIDTH-1:0] << (KW'(IN_WIDTH - 1) - s1_k);
  assign lut_idx = mant[IN_WIDTH-2 -: LUT_BITS];

  log2_lut #(
    .LUT_BITS  (LUT_BITS),
    .FRAC_BITS (FRAC_BITS)
  ) u_lut (
    .idx  (s2.data[LUT_BITS-1:0]),
    .frac (lut_frac)
  );

  // S3: integer part from k, fraction from the table.
  assign log2_val = (STAGE_DATA_W'(s2_k) << FRAC_BITS) + STAGE_DATA_W'(lut_frac);

  // S4: optional scale by ln(2) with round-half-up, zero saturates.
  always_comb begin
    prod = 64'(s3.data) * 64'(LN2_Q16) + (64'd1 << (LN2_SHIFT - 1));
    if (s3.zero)      s4_data = STAGE_DATA_W'(SAT_MIN);
    else if (s3.mode) s4_data = prod[LN2_SHIFT +: STAGE_DATA_W];
    else              s4_data = s3.data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      s4   <= '0;
      s1_k <= '0;
      s2_k <= '0;
    end else if (advance) begin
      s1.valid <= filtered_valid_in;
      s1.chan  <= STAGE_CHAN_W'(filtered_chan_in);
      s1.mode  <= filtered_mode_in;
      s1.zero  <= (filtered_data_in == '0);
      s1.data  <= STAGE_DATA_W'(filtered_data_in);
      s1_k     <= lod_k;
      s2       <= s1;
      s2.data  <= STAGE_DATA_W'(lut_idx);
      s2_k     <= s1_k;
      s3       <= s2;
      s3.data  <= log2_val;
      s4       <= s3;
      s4.data  <= s4_data;
    end
  end

  assign log_valid_out = s4.valid;
  assign log_data_out  = s4.data[OUT_WIDTH-1:0];
  assign log_chan_out  = s4.chan[CW-1:0];
  assign log_zero_out  = s4.zero;

  assign unused_bits = ^{s1.data, mant, s2.data, s4, prod};

endmodule

// File: tb/tb_log2_pipe.sv
// Scoreboard bench for log2_pipe: directed vectors, stall, throttled stream, mid-cycle reset.
module tb_log2_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] din = '0;
  logic [1:0]  chan_in = '0;
  logic        mode_in = 1'b0;
  logic        vin = 1'b0;
  logic        rdy;
  logic [15:0] dout;
  logic [1:0]  chan_out;
  logic        zero_out;
  logic        vout;
  logic        log_ready = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int ready_mode = 0;   // 0: always high, 1: high one cycle in three, 2: held low
  bit check_lat = 1'b0;

  logic [18:0] exp_q[$];   // {zero, chan, data}
  int          acc_q[$];   // capture edge index of each queued sample

  log2_pipe dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .filtered_data_in   (din),
    .filtered_chan_in   (chan_in),
    .filtered_mode_in   (mode_in),
    .filtered_valid_in  (vin),
    .filtered_ready_out (rdy),
    .log_data_out       (dout),
    .log_chan_out       (chan_out),
    .log_zero_out       (zero_out),
    .log_valid_out      (vout),
    .log_ready_in       (log_ready)
  );

  // ---------------- clock / reset / downstream ready ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (ready_mode)
      0:       log_ready = 1'b1;
      1:       log_ready = (cyc % 3 == 0);
      default: log_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Independent reference: real-valued log2 table, integer ln scaling.
  function automatic logic [15:0] model(input logic [31:0] x, input logic md);
    int     k;
    int     idx;
    int     lut;
    longint l2;
    longint ln;
    real    f;
    if (x == 32'd0) return 16'h8000;
    k = 0;
    for (int i = 0; i < 32; i++) if (x[i]) k = i;
    if (k >= 6) idx = int'((x >> (k - 6)) & 32'h3f);
    else        idx = int'((x << (6 - k)) & 32'h3f);
    f   = $ln(1.0 + real'(idx) / 64.0) / $ln(2.0) * 1024.0;
    lut = $rtoi(f + 0.5);
    l2  = longint'(k) * 1024 + longint'(lut);
    if (!md) return 16'(l2);
    ln = (l2 * 45426 + 32768) >>> 16;
    return 16'(ln);
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] x, input logic [1:0] ch, input logic md,
                      input logic [15:0] ed, input logic ez);
    int waited = 0;
    @(negedge clk);
    din = x; chan_in = ch; mode_in = md; vin = 1'b1;
    #1;
    while (!rdy && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!rdy) begin
      check("send_accept", {31'd0, rdy}, 32'd1);
      vin = 1'b0;
    end else begin
      exp_q.push_back({ez, ch, ed});
      acc_q.push_back(cyc + 1);
      @(posedge clk);
      #1 vin = 1'b0;
    end
  endtask

  task automatic send_model(input logic [31:0] x, input logic [1:0] ch, input logic md);
    send(x, ch, md, model(x, md), (x == 32'd0));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #3;
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [18:0] got_w;
  logic [18:0] exp_w;
  int          acc_c;

  always @(negedge clk) begin
    #2;
    if (rst_n && vout) begin
      got_w = {zero_out, chan_out, dout};
      if (exp_q.size() == 0) begin
        check("unexpected_output", {13'd0, got_w}, 32'd0);
      end else if (log_ready) begin
        exp_w = exp_q.pop_front();
        acc_c = acc_q.pop_front();
        check("result", {13'd0, got_w}, {13'd0, exp_w});
        if (check_lat) check("latency_edges", cyc - acc_c, 32'd3);
      end else begin
        check("held_while_stalled", {13'd0, got_w}, {13'd0, exp_q[0]});
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_valid", {31'd0, vout}, 32'd0);
    check("reset_data", {16'd0, dout}, 32'd0);
    check("reset_chan", {30'd0, chan_out}, 32'd0);
    check("reset_zero", {31'd0, zero_out}, 32'd0);
    check("reset_ready", {31'd0, rdy}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("ready_after_reset", {31'd0, rdy}, 32'd1);

    // Directed vectors with hand-computed results, ready held high.
    check_lat = 1'b1;
    send(32'd1,          2'd0, 1'b0, 16'h0000, 1'b0);
    send(32'd1024,       2'd1, 1'b0, 16'd10240, 1'b0);
    send(32'd1024,       2'd2, 1'b1, 16'd7098, 1'b0);
    send(32'hFFFF_FFFF,  2'd3, 1'b0, 16'd32756, 1'b0);
    send(32'd0,          2'd0, 1'b0, 16'h8000, 1'b1);
    send(32'd0,          2'd1, 1'b1, 16'h8000, 1'b1);
    send(32'd2,          2'd2, 1'b0, 16'd1024, 1'b0);
    send(32'd3,          2'd3, 1'b0, 16'd1623, 1'b0);
    send(32'h8000_0000,  2'd0, 1'b1, 16'd22003, 1'b0);
    wait_drain(50);
    check_lat = 1'b0;

    // Fill the pipe with the output stalled, hold 10 cycles, then release.
    ready_mode = 2;
    send_model(32'd5,       2'd1, 1'b0);
    send_model(32'd100,     2'd2, 1'b1);
    send_model(32'd7777,    2'd3, 1'b0);
    send_model(32'h10_0000, 2'd0, 1'b1);
    repeat (10) begin
      @(negedge clk);
      #1 check("stall_ready_low", {31'd0, rdy}, 32'd0);
    end
    ready_mode = 0;
    wait_drain(50);

    // Stream 1..1023 with downstream ready high one cycle in three.
    ready_mode = 1;
    for (int i = 1; i <= 1023; i++) begin
      send_model(32'(i), 2'(i % 4), (i % 5 == 0));
    end
    wait_drain(400);
    ready_mode = 0;

    // Reset between edges with samples in flight: all of them are dropped.
    send_model(32'd300,  2'd1, 1'b0);
    send_model(32'd4000, 2'd2, 1'b1);
    send_model(32'd9,    2'd3, 1'b0);
    @(posedge clk);
    #2 check("valid_before_reset", {31'd0, vout}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_valid", {31'd0, vout}, 32'd0);
    check("midreset_data", {16'd0, dout}, 32'd0);
    check("midreset_ready", {31'd0, rdy}, 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("ready_after_midreset", {31'd0, rdy}, 32'd1);
    repeat (8) @(negedge clk);

    check_lat = 1'b1;
    send(32'd1024, 2'd3, 1'b0, 16'd10240, 1'b0);
    wait_drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/log2_pipe.md
LOG2_PIPE -- requirements
Module: log2_pipe

Interface
REQ-001 Parameter IN_WIDTH, 32, unsigned input sample width (8..32).
REQ-002 Parameter OUT_WIDTH, 16, signed output width.
REQ-003 Parameter FRAC_BITS, 10, output fractional bits, Q(OUT_WIDTH-FRAC_BITS).FRAC_BITS.
REQ-004 Parameter LUT_BITS, 6, mantissa bits indexing the fraction LUT.
REQ-005 Parameter CHANNELS, 4, number of time-multiplexed channels carried as a tag.
REQ-006 clk_in  input  1  system clock, all logic rising-edge.
REQ-007 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-008 filtered_data_in  input  IN_WIDTH  unsigned sample.
REQ-009 filtered_chan_in  input  $clog2(CHANNELS)  channel tag of the sample.
REQ-010 filtered_mode_in  input  1  0 = log2, 1 = natural log.
REQ-011 filtered_valid_in  input  1  sample valid.
REQ-012 filtered_ready_out  output  1  block accepts a sample this cycle.
REQ-013 log_data_out  output  OUT_WIDTH  signed result.
REQ-014 log_chan_out  output  $clog2(CHANNELS)  tag matching log_data_out.
REQ-015 log_zero_out  output  1  input was zero; result saturated.
REQ-016 log_valid_out  output  1  result valid.
REQ-017 log_ready_in  input  1  downstream accepts result.

Function
REQ-018 Transfer occurs only on a cycle with valid and ready both high, on each side.
REQ-019 4-stage pipeline: S1 leading-one detect, S2 normalise, S3 LUT fraction + integer concat, S4 mode scale; latency exactly 4 cycles with log_ready_in held high.
REQ-020 Throughput one sample per cycle while log_ready_in is high.
REQ-021 filtered_ready_out = !S4_valid || log_ready_in; on stall all stages hold, nothing dropped or duplicated.
REQ-022 S1: k = index of most significant set bit of the input (0..IN_WIDTH-1).
REQ-023 S2: mantissa = input shifted left so bit k is at MSB; LUT index = next LUT_BITS bits below the leading one, zero-filled when k < LUT_BITS.
REQ-024 S3: LUT[i] = round(log2(1 + i/2^LUT_BITS) * 2^FRAC_BITS); log2 result = (k << FRAC_BITS) + LUT[i].
REQ-025 S4 mode 1: result = (log2 result * LN2_Q16 + 2^15) >> 16, LN2_Q16 = 45426; mode 0: passthrough.
REQ-026 Input zero: log_data_out = -2^(OUT_WIDTH-1), log_zero_out = 1, either mode.
REQ-027 Non-zero inputs: log_zero_out = 0, result always >= 0.
REQ-028 Channel tag and mode travel with the sample unchanged through all stages.
REQ-029 log_data_out, log_chan_out, log_zero_out held stable while log_valid_out high and log_ready_in low.
REQ-030 Bubbles (valid_in low) propagate as invalid stages; invalid stages are overwritten freely.

Reset
REQ-031 rst_n_in low clears all stage valid bits immediately (asynchronous), independent of clk_in.
REQ-032 During reset: log_valid_out = 0, log_data_out = 0, log_chan_out = 0, log_zero_out = 0, filtered_ready_out = 0.
REQ-033 First cycle after deassertion: filtered_ready_out = 1; in-flight samples at reset are discarded, never emitted.

Structure
REQ-034 Package log2_pkg holds LN2_Q16, default parameter values, and the stage record typedef (valid, chan, mode, zero, data).
REQ-035 One sub-module, log2_lut, SHALL provide the combinational fraction table generated from LUT_BITS and FRAC_BITS at elaboration.
REQ-036 Leading-one detect and normalise remain inline in log2_pipe.

Verification
REQ-037 x=1, mode 0, ready high -> 0x0000 four cycles after acceptance, zero_out 0.
REQ-038 x=1024 mode 0 -> 10240; x=1024 mode 1 -> 7098; x=0xFFFFFFFF mode 0 -> 32756.
REQ-039 x=0 in both modes -> -32768 (0x8000), log_zero_out 1.
REQ-040 Stream 1..1023 with log_ready_in toggling 1-of-3 -> every result exact vs REQ-024 model, in order, tags preserved, no loss.
REQ-041 log_ready_in low for 10 cycles with pipeline full -> filtered_ready_out low, outputs stable, resume without loss.
REQ-042 rst_n_in pulsed low mid-stream between clock edges -> log_valid_out drops immediately, no stale result after release.
